// File: rtl/dvi_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : dvi_lock_supervisor
// Description : Supervises the DVI PLL lock: waits for a settled lock before
//               releasing the video reset, and pulses the PLL reset on timeout.
//               Optional loss-event counter: DVI_LOCK_SUPERVISOR_LOSS_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dvi_lock_supervisor #(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int RST_PULSE      = 16
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_resetn,
    output logic       ready,
    output logic [7:0] loss_count
);

    localparam int c_max_a   = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int c_max     = (c_max_a > RST_PULSE) ? c_max_a : RST_PULSE;
    localparam int c_timer_w = (c_max > 1) ? $clog2(c_max) : 1;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_RETRY     = 2'd3
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [c_timer_w-1:0]   r_timer_q, w_timer_d;
    logic                   r_sync1_q, r_sync2_q;
    logic                   r_ready_q, w_ready_d;
    logic                   r_pll_rst_q, w_pll_rst_d;

    // r_sync2_q is the synchronized lock; nothing else looks at pll_locked.
    always_ff @(posedge clkin) begin
        if (!resetn) begin
            r_sync1_q   <= 1'b0;
            r_sync2_q   <= 1'b0;
            r_state_q   <= ST_WAIT_LOCK;
            r_timer_q   <= '0;
            r_ready_q   <= 1'b0;
            r_pll_rst_q <= 1'b0;
        end else begin
            r_sync1_q   <= pll_locked;
            r_sync2_q   <= r_sync1_q;
            r_state_q   <= w_state_d;
            r_timer_q   <= w_timer_d;
            r_ready_q   <= w_ready_d;
            r_pll_rst_q <= w_pll_rst_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_timer_d   = r_timer_q + c_timer_w'(1);
        w_ready_d   = (r_state_q == ST_RUN);
        w_pll_rst_d = (r_state_q == ST_RETRY);
        case (r_state_q)
            ST_WAIT_LOCK: begin
                if (r_sync2_q) begin
                    w_state_d = ST_SETTLE;
                    w_timer_d = '0;
                end else if (r_timer_q == c_timer_w'(TIMEOUT_CYCLES - 1)) begin
                    w_state_d = ST_RETRY;
                    w_timer_d = '0;
                end
            end
            ST_SETTLE: begin
                if (!r_sync2_q) begin
                    w_state_d = ST_WAIT_LOCK;
                    w_timer_d = '0;
                end else if (r_timer_q == c_timer_w'(SETTLE_CYCLES - 1)) begin
                    w_state_d = ST_RUN;
                    w_timer_d = '0;
                end
            end
            ST_RUN: begin
                w_timer_d = '0;
                if (!r_sync2_q) begin
                    w_state_d = ST_WAIT_LOCK;
                end
            end
            ST_RETRY: begin
                // Lock is deliberately ignored while the PLL is held in reset.
                if (r_timer_q == c_timer_w'(RST_PULSE - 1)) begin
                    w_state_d = ST_WAIT_LOCK;
                    w_timer_d = '0;
                end
            end
            default: begin
                w_state_d = ST_WAIT_LOCK;
                w_timer_d = '0;
            end
        endcase
    end

    assign pll_rst    = r_pll_rst_q;
    assign ready      = r_ready_q;
    assign sys_resetn = r_ready_q;

`ifdef DVI_LOCK_SUPERVISOR_LOSS_COUNT_EN
    logic [7:0] r_loss_q, w_loss_d;

    always_comb begin
        w_loss_d = r_loss_q;
        if ((r_state_q == ST_RUN) && !r_sync2_q && (r_loss_q != 8'hFF)) begin
            w_loss_d = r_loss_q + 8'd1;
        end
    end

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            r_loss_q <= 8'd0;
        end else begin
            r_loss_q <= w_loss_d;
        end
    end

    assign loss_count = r_loss_q;
`else
    assign loss_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dvi_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_dvi_lock_supervisor
// Description : Randomized bench for dvi_lock_supervisor with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvi_lock_supervisor;

    localparam int S = 8;
    localparam int T = 100;
    localparam int P = 4;

    logic       clkin = 1'b0;
    logic       resetn;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_resetn;
    logic       ready;
    logic [7:0] loss_count;

    int checks   = 0;
    int failures = 0;

`ifdef DVI_LOCK_SUPERVISOR_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    dvi_lock_supervisor #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .RST_PULSE     (P)
    ) dut (
        .clkin     (clkin),
        .resetn    (resetn),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_resetn(sys_resetn),
        .ready     (ready),
        .loss_count(loss_count)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases described by elapsed-cycle counts, lock seen
    // through a two-deep delay queue, outputs lag the phase by one cycle.
    localparam int PH_WAIT   = 0;
    localparam int PH_SETTLE = 1;
    localparam int PH_RUN    = 2;
    localparam int PH_RETRY  = 3;

    initial begin
        int phase, elapsed, exp_ready, exp_prst, exp_loss;
        bit valid, lk;
        bit dly[$];
        valid = 0; phase = PH_WAIT; elapsed = 0;
        exp_ready = 0; exp_prst = 0; exp_loss = 0;
        dly = '{1'b0, 1'b0};
        forever begin
            @(posedge clkin);
            #1;
            if (resetn !== 1'b1) begin
                valid = 1; phase = PH_WAIT; elapsed = 0;
                exp_ready = 0; exp_prst = 0; exp_loss = 0;
                dly = '{1'b0, 1'b0};
            end else if (valid) begin
                lk        = dly[0];
                exp_ready = (phase == PH_RUN) ? 1 : 0;
                exp_prst  = (phase == PH_RETRY) ? 1 : 0;
                if (phase == PH_WAIT) begin
                    if (lk) begin phase = PH_SETTLE; elapsed = 0; end
                    else if (elapsed + 1 >= T) begin phase = PH_RETRY; elapsed = 0; end
                    else elapsed++;
                end else if (phase == PH_SETTLE) begin
                    if (!lk) begin phase = PH_WAIT; elapsed = 0; end
                    else if (elapsed + 1 >= S) begin phase = PH_RUN; elapsed = 0; end
                    else elapsed++;
                end else if (phase == PH_RUN) begin
                    if (!lk) begin
                        phase = PH_WAIT; elapsed = 0;
                        if (LOSS_EN && exp_loss < 255) exp_loss++;
                    end
                end else begin
                    if (elapsed + 1 >= P) begin phase = PH_WAIT; elapsed = 0; end
                    else elapsed++;
                end
                void'(dly.pop_front());
                dly.push_back(pll_locked);
            end
            if (valid) begin
                check("ready", int'(ready), exp_ready);
                check("sys_resetn", int'(sys_resetn), exp_ready);
                check("pll_rst", int'(pll_rst), exp_prst);
                check("loss_count", int'(loss_count), exp_loss);
            end
        end
    end

    task automatic wait_level(input logic lvl, input bit use_rst, input int bound, output int n);
        n = 0;
        while (n < bound && ((use_rst ? pll_rst : ready) !== lvl)) begin
            @(negedge clkin);
            n++;
        end
        if ((use_rst ? pll_rst : ready) !== lvl) check("wait_timeout", 0, 1);
    endtask

    initial begin
        int n, w;
        resetn = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge clkin);
        check("rst_ready", int'(ready), 0);
        check("rst_sys_resetn", int'(sys_resetn), 0);
        check("rst_pll_rst", int'(pll_rst), 0);
        check("rst_loss", int'(loss_count), 0);
        resetn = 1'b1;

        // Normal lock: ready 2 sync + 1 entry + S settle + 1 output cycles later.
        repeat (5) @(negedge clkin);
        pll_locked = 1'b1;
        wait_level(1'b1, 1'b0, 40, n);
        check("lock_latency", n, 2 + 1 + S + 1);

        // Settle glitch: a drop during settling restarts the count from zero.
        pll_locked = 1'b0;
        wait_level(1'b0, 1'b0, 20, n);
        repeat (4) @(negedge clkin);
        pll_locked = 1'b1;
        repeat (7) @(negedge clkin);
        pll_locked = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clkin);
        check("glitch_no_ready", int'(ready), 0);
        pll_locked = 1'b1;
        wait_level(1'b1, 1'b0, 40, n);
        check("glitch_latency", n, 2 + 1 + S + 1);

        // Timeout: PLL reset pulse width.
        pll_locked = 1'b0;
        wait_level(1'b1, 1'b1, 300, n);
        w = 0;
        while (pll_rst === 1'b1 && w < 20) begin
            w++;
            @(negedge clkin);
        end
        check("rst_pulse_width", w, P);
        check("retry_sys_resetn", int'(sys_resetn), 0);

        // Reset in the middle of a retry pulse.
        wait_level(1'b1, 1'b1, 300, n);
        resetn = 1'b0;
        @(negedge clkin);
        check("mid_retry_pll_rst", int'(pll_rst), 0);
        resetn = 1'b1;

        // Lock losses while running.
        pll_locked = 1'b1;
        wait_level(1'b1, 1'b0, 40, n);
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clkin);
            pll_locked = 1'b1;
            wait_level(1'b0, 1'b0, 10, n);
            wait_level(1'b1, 1'b0, 40, n);
            if (i == 2) check("loss_after_3", int'(loss_count), LOSS_EN ? 3 : 0);
        end
        check("loss_saturated", int'(loss_count), LOSS_EN ? 255 : 0);

        // Reset during RUN clears every output on the same edge.
        resetn = 1'b0;
        @(negedge clkin);
        check("runrst_ready", int'(ready), 0);
        check("runrst_sys_resetn", int'(sys_resetn), 0);
        check("runrst_pll_rst", int'(pll_rst), 0);
        check("runrst_loss", int'(loss_count), 0);
        resetn = 1'b1;

        // Random lock behaviour with occasional resets.
        for (int i = 0; i < 150; i++) begin
            pll_locked = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) resetn = 1'b0;
            @(negedge clkin);
            resetn = 1'b1;
            repeat ($urandom_range(1, 30)) @(negedge clkin);
        end
        pll_locked = 1'b0;
        repeat (250) @(negedge clkin);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
